// File: rtl/card_pkg.sv
// ============================================================================
// Module      : card_pkg
// Description : Shared types and defaults for the 1402 card read capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package card_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_UNLOAD  = 2'd2
    } card_state_t;

    // Buffer row slots in cam order: rows 12 and 11 come before 0..9.
    typedef enum logic [3:0] {
        ROW12 = 4'd0,  ROW11 = 4'd1,  ROW0 = 4'd2,  ROW1 = 4'd3,
        ROW2  = 4'd4,  ROW3  = 4'd5,  ROW4 = 4'd6,  ROW5 = 4'd7,
        ROW6  = 4'd8,  ROW7  = 4'd9,  ROW8 = 4'd10, ROW9 = 4'd11
    } row_slot_t;

    localparam int DEF_COLS        = 80;
    localparam int DEF_ROWS        = 12;
    localparam int DEF_ARM_ANGLE   = 0;
    localparam int DEF_ABORT_ANGLE = 240;

endpackage

`default_nettype wire

// File: rtl/card_row_buf.sv
// ============================================================================
// Module      : card_row_buf
// Description : ROWS x COLS card image; row-wide write, column-wide read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module card_row_buf #(
    parameter int COLS = 80,
    parameter int ROWS = 12
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [$clog2(ROWS)-1:0]   wr_row,
    input  logic [COLS-1:0]           wr_data,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [ROWS-1:0]           rd_code
);

    logic [COLS-1:0] mem_q [ROWS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_row] <= wr_data;
        end
    end

    // Slot 0 lands on the code MSB so the code reads 12,11,0..9 left to right.
    always_comb begin
        rd_code = '0;
        for (int r = 0; r < ROWS; r++) begin
            rd_code[ROWS-1-r] = mem_q[r][rd_col];
        end
    end

endmodule

`default_nettype wire

// File: rtl/card_read_capture.sv
// ============================================================================
// Module      : card_read_capture
// Description : Samples 12 brush rows per clutched revolution, then unloads
//               the card column by column as Hollerith codes (valid/ready).
//               Optional READ_CHECK_EN adds a brush/check-brush popcount compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module card_read_capture
    import card_pkg::*;
#(
    parameter int COLS        = DEF_COLS,
    parameter int ROWS        = DEF_ROWS,
    parameter int ARM_ANGLE   = DEF_ARM_ANGLE,
    parameter int ABORT_ANGLE = DEF_ABORT_ANGLE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             clch_angle,
    input  logic                    sccb,
    input  logic                    card_present,
    input  logic [COLS-1:0]         brush,
    input  logic [COLS-1:0]         brush_chk,
    input  logic                    err_clr,
    input  logic                    col_ready,
    output logic                    col_valid,
    output logic [$clog2(COLS)-1:0] col_idx,
    output logic [ROWS-1:0]         col_code,
    output logic                    busy,
    output logic                    card_done,
    output logic                    overrun,
    output logic                    short_read,
    output logic                    read_err
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    card_state_t    state_q;
    logic [RW-1:0]  row_cnt_q;
    logic           sccb_q;
    logic           col_valid_q;
    logic [CW-1:0]  col_idx_q;
    logic           busy_q;
    logic           card_done_q;
    logic           overrun_q;
    logic           short_read_q;

    logic           w_arm;
    logic           w_abort;
    logic           w_sample;
    logic           w_last_row;
    logic           w_xfer;
    logic           w_last_col;
    logic [ROWS-1:0] w_rd_code;

    assign w_arm      = (clch_angle == 32'(ARM_ANGLE)) && card_present;
    // row_cnt never reaches ROWS while capturing, so the angle alone decides.
    assign w_abort    = (clch_angle == 32'(ABORT_ANGLE));
    assign w_sample   = (state_q == ST_CAPTURE) && sccb && !sccb_q && !w_abort;
    assign w_last_row = (row_cnt_q == RW'(ROW9));
    assign w_xfer     = col_valid_q && col_ready;
    assign w_last_col = (col_idx_q == CW'(COLS - 1));

`ifdef READ_CHECK_EN
    localparam int PCW = $clog2(COLS + 1);
    logic [PCW-1:0] w_pc_brush;
    logic [PCW-1:0] w_pc_chk;
    logic           w_row_mismatch;
    logic           chk_acc_q;
    logic           read_err_q;

    always_comb begin
        w_pc_brush = '0;
        w_pc_chk   = '0;
        for (int i = 0; i < COLS; i++) begin
            w_pc_brush = w_pc_brush + PCW'(brush[i]);
            w_pc_chk   = w_pc_chk   + PCW'(brush_chk[i]);
        end
    end

    assign w_row_mismatch = (w_pc_brush != w_pc_chk);
    assign read_err       = read_err_q;
`else
    logic w_unused_chk;
    assign w_unused_chk = ^brush_chk;
    assign read_err     = 1'b0;
`endif

    card_row_buf #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_row_buf (
        .clk     (clk),
        .wr_en   (w_sample),
        .wr_row  (row_cnt_q),
        .wr_data (brush),
        .rd_col  (col_idx_q),
        .rd_code (w_rd_code)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            row_cnt_q    <= '0;
            sccb_q       <= 1'b0;
            col_valid_q  <= 1'b0;
            col_idx_q    <= '0;
            busy_q       <= 1'b0;
            card_done_q  <= 1'b0;
            overrun_q    <= 1'b0;
            short_read_q <= 1'b0;
`ifdef READ_CHECK_EN
            chk_acc_q    <= 1'b0;
            read_err_q   <= 1'b0;
`endif
        end else begin
            sccb_q      <= sccb;
            card_done_q <= 1'b0;

            // Clears come first so a same-cycle set further down wins.
            if (err_clr) begin
                overrun_q    <= 1'b0;
                short_read_q <= 1'b0;
`ifdef READ_CHECK_EN
                read_err_q   <= 1'b0;
`endif
            end

            case (state_q)
                ST_IDLE: begin
                    if (w_arm) begin
                        state_q   <= ST_CAPTURE;
                        busy_q    <= 1'b1;
                        row_cnt_q <= '0;
`ifdef READ_CHECK_EN
                        chk_acc_q <= 1'b0;
`endif
                    end
                end

                ST_CAPTURE: begin
                    if (w_abort) begin
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                        short_read_q <= 1'b1;
                    end else if (w_sample) begin
`ifdef READ_CHECK_EN
                        chk_acc_q <= chk_acc_q | w_row_mismatch;
`endif
                        if (w_last_row) begin
                            state_q     <= ST_UNLOAD;
                            col_valid_q <= 1'b1;
                            col_idx_q   <= '0;
`ifdef READ_CHECK_EN
                            if (chk_acc_q || w_row_mismatch) begin
                                read_err_q <= 1'b1;
                            end
`endif
                        end else begin
                            row_cnt_q <= row_cnt_q + RW'(1);
                        end
                    end
                end

                ST_UNLOAD: begin
                    if (w_xfer && w_last_col) begin
                        card_done_q <= 1'b1;
                        col_valid_q <= 1'b0;
                        col_idx_q   <= '0;
                        state_q     <= ST_IDLE;
                        busy_q      <= 1'b0;
                    end else if (w_xfer) begin
                        col_idx_q <= col_idx_q + CW'(1);
                    end

                    // A new card at the station pre-empts the unload.
                    if (w_arm) begin
                        if (!(w_xfer && w_last_col)) begin
                            overrun_q <= 1'b1;
                        end
                        state_q     <= ST_CAPTURE;
                        busy_q      <= 1'b1;
                        col_valid_q <= 1'b0;
                        col_idx_q   <= '0;
                        row_cnt_q   <= '0;
`ifdef READ_CHECK_EN
                        chk_acc_q   <= 1'b0;
`endif
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    col_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign col_valid  = col_valid_q;
    assign col_idx    = col_idx_q;
    assign col_code   = col_valid_q ? w_rd_code : '0;
    assign busy       = busy_q;
    assign card_done  = card_done_q;
    assign overrun    = overrun_q;
    assign short_read = short_read_q;

endmodule

`default_nettype wire

// File: tb/tb_card_read_capture.sv
// ============================================================================
// Module      : tb_card_read_capture
// Description : Randomized scoreboard bench for card_read_capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_card_read_capture;

    localparam int COLS = 80;
    localparam int ROWS = 12;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     clch_angle;
    logic            sccb;
    logic            card_present;
    logic [COLS-1:0] brush;
    logic [COLS-1:0] brush_chk;
    logic            err_clr;
    logic            col_ready;
    logic            col_valid;
    logic [6:0]      col_idx;
    logic [11:0]     col_code;
    logic            busy;
    logic            card_done;
    logic            overrun;
    logic            short_read;
    logic            read_err;

    card_read_capture #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .ARM_ANGLE   (0),
        .ABORT_ANGLE (240)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clch_angle   (clch_angle),
        .sccb         (sccb),
        .card_present (card_present),
        .brush        (brush),
        .brush_chk    (brush_chk),
        .err_clr      (err_clr),
        .col_ready    (col_ready),
        .col_valid    (col_valid),
        .col_idx      (col_idx),
        .col_code     (col_code),
        .busy         (busy),
        .card_done    (card_done),
        .overrun      (overrun),
        .short_read   (short_read),
        .read_err     (read_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [11:0] code;
    } col_t;

    col_t            exp_q[$];
    int              n_chk  = 0;
    int              n_pass = 0;
    logic [COLS-1:0] img [ROWS];
    bit              ovr_exp;
    bit              sr_exp;
    bit              re_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [COLS-1:0] rand_row();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[COLS-1:0];
    endfunction

    task automatic rand_img();
        foreach (img[r]) img[r] = rand_row();
    endtask

    // Hollerith code of a column: the first-sampled row (12) is the MSB.
    function automatic logic [11:0] ref_code(input int c);
        logic [11:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) v[11-r] = img[r][c];
        return v;
    endfunction

    // One clutched revolution. rmode: 0 random ready, 1 always, 2 never,
    // 3 stall 10 cycles at column 5, 4 ready with reset at column 37.
    task automatic run_rev(input int nrows, input bit present, input int rmode,
                           input int chk_slot, input bit clr);
        bit bexp;
        bit samp;
        int k;
        int ph;
        bexp = present || (exp_q.size() > 0);
        if (present && exp_q.size() > 0) begin
            ovr_exp = 1'b1;
            exp_q.delete();
        end
        if (present && nrows == ROWS)
            for (int c = 0; c < COLS; c++) exp_q.push_back('{idx: c, code: ref_code(c)});

        for (int a = 0; a < 360; a++) begin
            @(posedge clk);
            #1;
            clch_angle   = a;
            card_present = present;
            sccb         = 1'b0;
            samp         = 1'b0;
            k            = 0;
            if (a >= 12 && a < 12 + 18 * ROWS) begin
                k  = (a - 12) / 18;
                ph = (a - 12) % 18;
                sccb = (k < nrows) && (ph < 2);
                samp = (k < nrows) && (ph == 0);
            end
            brush     = samp ? img[k] : rand_row();
            brush_chk = brush;
            if (samp && k == chk_slot) brush_chk[7] = ~brush[7];

            case (rmode)
                0:       col_ready = ($urandom_range(3) != 0);
                1, 4:    col_ready = 1'b1;
                2:       col_ready = 1'b0;
                default: col_ready = !(a >= 216 && a <= 225);
            endcase
            if (a < 12) col_ready = 1'b0;
            err_clr = clr && (a == 300);

            if (a == 1) begin
                chk("busy_after_arm", busy, bexp);
                chk("overrun_flag", overrun, ovr_exp);
                chk("short_read_flag", short_read, sr_exp);
                chk("read_err_flag", read_err, re_exp);
            end
            if (a == 211 && present && nrows == ROWS) begin
`ifdef READ_CHECK_EN
                if (chk_slot >= 0) re_exp = 1'b1;
`endif
                chk("read_err_after_row12", read_err, re_exp);
                chk("valid_after_row12", col_valid, 1);
            end
            if (a == 241 && present && nrows < ROWS) begin
                sr_exp = 1'b1;
                chk("short_read_set", short_read, sr_exp);
                chk("short_read_idle", {busy, col_valid}, 0);
            end
            if (a == 225 && rmode == 3) begin
                chk("bp_valid", col_valid, 1);
                chk("bp_idx", col_idx, 5);
            end
            if (a == 301 && clr) begin
                ovr_exp = 1'b0;
                sr_exp  = 1'b0;
                re_exp  = 1'b0;
                chk("flags_cleared", {overrun, short_read, read_err}, 0);
            end
            if (rmode == 4 && a == 248) begin
                chk("idx_before_rst", col_idx, 37);
                rst = 1'b1;
                #1;
                chk("rst_pending_cols", exp_q.size(), 43);
                exp_q.delete();
                ovr_exp = 1'b0;
                sr_exp  = 1'b0;
                re_exp  = 1'b0;
                chk("rst_mid_unload_outputs",
                    {col_valid, col_idx, col_code, busy, card_done, overrun, short_read, read_err}, 0);
            end
            if (rmode == 4 && a == 250) rst = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard on every accepted column.
    initial begin
        bit          done_pend;
        bit          hold_prev;
        logic [6:0]  idx_prev;
        logic [11:0] code_prev;
        col_t        e;
        done_pend = 1'b0;
        hold_prev = 1'b0;
        idx_prev  = '0;
        code_prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_pend = 1'b0;
                hold_prev = 1'b0;
            end else begin
                if (card_done || done_pend) chk("card_done_pulse", card_done, done_pend);
                done_pend = 1'b0;
                if (hold_prev && clch_angle >= 12) begin
                    chk("hold_stable", {col_valid, col_idx, col_code}, {1'b1, idx_prev, code_prev});
                end
                hold_prev = col_valid && !col_ready;
                idx_prev  = col_idx;
                code_prev = col_code;
                if (col_valid && col_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_column", {col_idx, col_code}, 0);
                        n_pass = n_pass; // failure already counted when nonzero
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("col%0d_idx", e.idx), col_idx, e.idx);
                        chk($sformatf("col%0d_code", e.idx), col_code, e.code);
                        if (e.idx == COLS - 1) done_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        clch_angle   = 100;
        sccb         = 1'b0;
        card_present = 1'b0;
        brush        = '0;
        brush_chk    = '0;
        err_clr      = 1'b0;
        col_ready    = 1'b0;
        ovr_exp      = 1'b0;
        sr_exp       = 1'b0;
        re_exp       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {col_valid, col_idx, col_code, busy, card_done, overrun, short_read, read_err}, 0);
        rst = 1'b0;

        // Directed card: col 0 rows 12 and 1 (0x900), col 79 row 9 (0x001).
        foreach (img[r]) img[r] = '0;
        img[0][0]   = 1'b1;
        img[3][0]   = 1'b1;
        img[11][79] = 1'b1;
        run_rev(12, 1'b1, 1, -1, 1'b0);

        rand_img(); run_rev(12, 1'b1, 3, -1, 1'b0);
        repeat (3) begin
            rand_img(); run_rev(12, 1'b1, 0, -1, 1'b0);
        end

        rand_img(); run_rev(5, 1'b1, 0, -1, 1'b1);

        rand_img(); run_rev(12, 1'b1, 2, -1, 1'b0);
        rand_img(); run_rev(12, 1'b1, 1, -1, 1'b1);

        rand_img(); run_rev(12, 1'b1, 2, -1, 1'b0);
        run_rev(12, 1'b0, 1, -1, 1'b0);

        rand_img(); run_rev(12, 1'b1, 1, 3, 1'b1);

        rand_img(); run_rev(12, 1'b1, 4, -1, 1'b0);
        rand_img(); run_rev(12, 1'b1, 0, -1, 1'b0);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        chk("idle_at_end", busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/card_read_capture.md
# card_read_capture

Downstream consumer of the clutched-shaft timing in the 1402 reader model. It watches the clutched shaft angle and the SCCB row-sample pulses, and samples the 80 read brushes once per card row (12 rows per clutched revolution). It buffers the card image and then unloads it column by column as 12-bit Hollerith codes over a valid/ready handshake to the translation logic.

## Interface
- `COLS`, 80, number of card columns / brush width.
- `ROWS`, 12, rows sampled per card (fixed row order 12, 11, 0..9).
- `ARM_ANGLE`, 0, clutched angle at which a capture is armed.
- `ABORT_ANGLE`, 240, clutched angle by which all rows must have been sampled.
- `clk`  in  1  model clock; one shaft degree per cycle while powered.
- `rst`  in  1  reset, asynchronous, active-high.
- `clch_angle`  in  32 (int)  clutched shaft angle, 0..359.
- `sccb`  in  1  row-sample cam pulse, 2 degrees wide, 12 per revolution.
- `card_present`  in  1  card lever; high when a card is at the read station.
- `brush`  in  COLS  read brush contacts; 1 means a hole is present.
- `brush_chk`  in  COLS  check-brush contacts (used only with READ_CHECK_EN).
- `err_clr`  in  1  clears the sticky error flags.
- `col_ready`  in  1  downstream accepts a column.
- `col_valid`  out  1  column code available.
- `col_idx`  out  7  column number, 0..COLS-1.
- `col_code`  out  12  bit 11 = row 12, bit 10 = row 11, bit 9 = row 0 … bit 0 = row 9.
- `busy`  out  1  state is not IDLE.
- `card_done`  out  1  one-cycle pulse when the last column is accepted.
- `overrun`, `short_read`, `read_err`  out  1 each  sticky error flags.

## Operation
- FSM states: IDLE, CAPTURE, UNLOAD.
- IDLE → CAPTURE:
  - Condition: at a posedge with `clch_angle==ARM_ANGLE` and `card_present==1`.
  - Action: row_cnt←0; the check accumulator is cleared.
- CAPTURE, sampling:
  - Rising edge of `sccb` is detected as `sccb & ~sccb_q` (sccb_q is the registered sccb).
  - On that edge, `brush` is written into buffer row slot row_cnt, and row_cnt increments.
  - When slot 11 is written → UNLOAD with col_idx←0.
- CAPTURE, short read: if `clch_angle==ABORT_ANGLE` and row_cnt<12 → IDLE, short_read←1, no columns emitted.
- SCCB edges are ignored in IDLE and UNLOAD.
- UNLOAD:
  - `col_code` = buffer bits [slot 0..11][col_idx], with slot 0 on bit 11.
  - A transfer occurs when col_valid & col_ready at a posedge; col_idx then increments.
  - On the transfer of column COLS-1: card_done pulses and the FSM returns to IDLE.
  - While col_ready=0, col_valid, col_idx and col_code hold stable.
- UNLOAD, overrun: if the arm condition occurs (angle==ARM_ANGLE, card_present=1):
  - overrun←1 and the remaining columns are dropped.
  - The FSM goes to CAPTURE with row_cnt←0, so the new card wins.
  - If the angle is ARM_ANGLE but card_present=0, unloading continues unaffected.
- Sticky flags:
  - A flag set and `err_clr` in the same cycle: the set wins.
  - `err_clr` does not affect the FSM.
- Angle stall (power off) simply freezes progress; no timeout exists.

## Timing
- Reset values (asynchronous): state IDLE; col_valid=0, col_idx=0, col_code=0, busy=0, card_done=0, overrun=0, short_read=0, read_err=0; sccb_q=0. Buffer contents are don't-care.
- Capture latency:
  - Brush data is sampled at the posedge where sccb is first seen high.
  - With the nominal cam schedule (SCCB at angles 12, 30 … 210), the last row is written at angle 210.
- Unload latency:
  - col_valid rises one cycle after the 12th row write.
  - Best case: 80 columns in 80 cycles, with card_done on the 80th accepting edge.
- busy is registered and asserts the cycle after arming.

## Configuration
- `READ_CHECK_EN` defined:
  - At each sampled row, popcount(brush) and popcount(brush_chk) are compared.
  - Any mismatch during a card sets read_err at the 12th-row edge.
- `READ_CHECK_EN` undefined: `brush_chk` is ignored, no popcount logic is built, and read_err is tied 0.

## Structure
- Shared package `card_pkg`:
  - FSM state enum.
  - Row-slot constants (ROW12=0, ROW11=1, ROW0=2 … ROW9=11).
  - Default ARM/ABORT angles.
  - COLS/ROWS defaults.
- Sub-module `card_row_buf`:
  - ROWS×COLS register array.
  - Row-wide write port (wr_en, wr_row, wr_data).
  - Column read port (rd_col → 12-bit code, combinational).

## Test plan
- Reset mid-UNLOAD (col_idx=37) → next cycle all outputs 0 and busy=0; a fresh card captures normally.
- Full card:
  - Stimulus: angle sweep 0..359, nominal SCCB, column 0 punched at rows 12 and 1, column 79 punched at row 9.
  - Response: col 0 code 0x900, col 79 code 0x001, other codes 0x000, card_done once.
- Backpressure: col_ready=0 for 10 cycles at col_idx=5 → col_valid=1 and col_idx=5 with code held stable; the next transfer is col 5.
- Overrun: col_ready=0 through the next angle 0 with card_present=1 → overrun=1, capture restarts, and the second card unloads from col 0.
- Short read: SCCB suppressed after 5 rows → at angle 240 short_read=1, col_valid never asserts, FSM in IDLE; err_clr clears the flag.
- READ_CHECK_EN: brush_chk differs by one bit at row slot 3 → read_err=1 after the 12th row; the same stimulus without the macro leaves read_err=0.
